// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: reset/step defaults,
// request FSM encoding and the queue entry layout.
package fetch_queue_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_STEP_DEF  = 32'h0000_0004;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } req_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Instruction cache request/response channel between the fetch queue
// (master) and the instruction cache (slave).
interface fetch_queue_if;

  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_handle;
  logic        inst_ready_in;
  logic [31:0] inst_in;

  modport master (
    output inst_req, inst_addr,
    input  inst_handle, inst_ready_in, inst_in
  );

  modport slave (
    input  inst_req, inst_addr,
    output inst_handle, inst_ready_in, inst_in
  );

endinterface

// File: rtl/fetch_queue_fifo.sv
// Circular storage for fetch_queue: DEPTH entries of WIDTH bits with
// push/pop/clear and an occupancy count; DEPTH must be a power of two.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    head_r;
  logic [AW-1:0]    tail_r;
  logic [AW:0]      count_r;

  // entry storage; stale contents are never visible because the reader masks with valid
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem_r[tail_r] <= wdata;
    end
  end

  // pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else if (clear) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      if (push) begin
        tail_r <= tail_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (pop) begin
        head_r <= head_r + {{(AW-1){1'b0}}, 1'b1};
      end
      count_r <= count_r + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  assign rdata = mem_r[head_r];
  assign count = count_r;
  assign empty = (count_r == {(AW+1){1'b0}});
  assign full  = (count_r == (AW+1)'(DEPTH));

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential cache requests, buffers responses
// for the decoder, handles flush/redirect. FETCH_BYPASS_EN adds an empty-queue bypass.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEF
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   deq_in,
  input  logic                   redirect_in,
  input  logic [31:0]            redirect_pc_in,
  output logic                   inst_ready_out,
  output logic [31:0]            inst_out,
  output logic [31:0]            inst_addr_out,
  output logic [$clog2(DEPTH):0] count_out,
  input  logic                   rob_clear,
  input  logic [31:0]            rob_rst_addr,
  fetch_queue_if.master          cache
);

  req_state_e  state_r, state_n;
  logic [31:0] fetch_pc_r, fetch_pc_n;
  logic [31:0] pend_addr_r, pend_addr_n;
  logic        flush_s, req_s, accept_s, resp_s, push_s, pop_s, fifo_push_s;
  logic        ready_s, fifo_empty_s, fifo_full_s;
  logic [31:0] push_addr_s;
  fq_entry_t   wr_entry_s, rd_entry_s, head_s;

  // request FSM, fetch PC and the address of the outstanding request
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_r     <= ST_IDLE;
      fetch_pc_r  <= RESET_PC;
      pend_addr_r <= 32'h0000_0000;
    end else begin
      state_r     <= state_n;
      fetch_pc_r  <= fetch_pc_n;
      pend_addr_r <= pend_addr_n;
    end
  end

  // next state, PC update and push decision
  always_comb begin
    flush_s     = rdy_in & (rob_clear | redirect_in);
    req_s       = ~rst_in & rdy_in & (state_r == ST_IDLE) & ~fifo_full_s & ~rob_clear & ~redirect_in;
    accept_s    = req_s & cache.inst_handle;
    resp_s      = rdy_in & cache.inst_ready_in;
    state_n     = state_r;
    fetch_pc_n  = fetch_pc_r;
    pend_addr_n = pend_addr_r;
    push_s      = 1'b0;
    push_addr_s = pend_addr_r;
    if (!rdy_in) begin
      state_n = state_r;
    end else if (flush_s) begin
      fetch_pc_n = rob_clear ? rob_rst_addr : redirect_pc_in;
      case (state_r)
        ST_WAIT: state_n = resp_s ? ST_IDLE : ST_DROP;
        ST_DROP: state_n = resp_s ? ST_IDLE : ST_DROP;
        default: state_n = ST_IDLE;
      endcase
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            fetch_pc_n = fetch_pc_r + PC_STEP;
            if (resp_s) begin
              push_s      = 1'b1;
              push_addr_s = fetch_pc_r;
            end else begin
              state_n     = ST_WAIT;
              pend_addr_n = fetch_pc_r;
            end
          end else begin
            state_n = ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (resp_s) begin
            push_s  = 1'b1;
            state_n = ST_IDLE;
          end else begin
            state_n = ST_WAIT;
          end
        end
        ST_DROP: state_n = resp_s ? ST_IDLE : ST_DROP;
        default: state_n = ST_IDLE;
      endcase
    end
  end

  assign wr_entry_s = '{inst: cache.inst_in, addr: push_addr_s};

  // head selection and storage write enable
  always_comb begin
`ifdef FETCH_BYPASS_EN
    // a response landing in an empty queue is presented directly and skips storage if taken
    ready_s     = (~fifo_empty_s | push_s) & ~flush_s;
    head_s      = fifo_empty_s ? wr_entry_s : rd_entry_s;
    fifo_push_s = push_s & ~(fifo_empty_s & deq_in);
`else
    ready_s     = ~fifo_empty_s & ~flush_s;
    head_s      = rd_entry_s;
    fifo_push_s = push_s;
`endif
    pop_s = rdy_in & deq_in & ready_s & ~fifo_empty_s;
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk   (clk_in),
    .rst   (rst_in),
    .clear (flush_s),
    .push  (fifo_push_s),
    .pop   (pop_s),
    .wdata (wr_entry_s),
    .rdata (rd_entry_s),
    .count (count_out),
    .empty (fifo_empty_s),
    .full  (fifo_full_s)
  );

  assign cache.inst_req  = req_s;
  assign cache.inst_addr = fetch_pc_r;
  assign inst_ready_out  = ready_s;
  assign inst_out        = ready_s ? head_s.inst : 32'h0000_0000;
  assign inst_addr_out   = ready_s ? head_s.addr : 32'h0000_0000;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a behavioural cache of configurable
// latency and a scoreboard of expected head entries.
module tb_fetch_queue;

  localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        deq;
  logic        redirect_in;
  logic [31:0] redirect_pc_in;
  logic        rob_clear;
  logic [31:0] rob_rst_addr;
  logic        inst_ready_out;
  logic [31:0] inst_out;
  logic [31:0] inst_addr_out;
  logic [$clog2(DEPTH):0] count_out;

  fetch_queue_if cif ();

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0), .PC_STEP(32'h4)) dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .rdy_in         (rdy),
    .deq_in         (deq),
    .redirect_in    (redirect_in),
    .redirect_pc_in (redirect_pc_in),
    .inst_ready_out (inst_ready_out),
    .inst_out       (inst_out),
    .inst_addr_out  (inst_addr_out),
    .count_out      (count_out),
    .rob_clear      (rob_clear),
    .rob_rst_addr   (rob_rst_addr),
    .cache          (cif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          ntests = 0;
  int          nfail  = 0;
  logic [63:0] sb[$];
  int          exp_cnt;
  logic [31:0] exp_pc;
  int          lat;
  bit          pend;
  bit          drop;
  logic [31:0] pend_a;
  int          wait_cnt;
  logic [31:0] junk_cnt;
  int          saved_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a == 32'h40) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0000);
  endfunction

  // One clock cycle: cache model, scoreboard and per-cycle checks.
  task automatic cyc();
    bit fl, from_pend, accepted, resp_now, pushed, popped, exp_rdy, exp_req;
    logic [31:0] raddr;
    logic [63:0] ent;
    fl        = rdy && (rob_clear || redirect_in);
    from_pend = 1'b0;
    accepted  = 1'b0;
    raddr     = 32'h0;
    cif.inst_handle = 1'b0;
    if (!rdy) begin
      cif.inst_ready_in = junk_cnt[0];
      cif.inst_in       = 32'hBAD0_0000 | junk_cnt;
      junk_cnt++;
    end else if (pend && wait_cnt == 0) begin
      cif.inst_ready_in = 1'b1;
      cif.inst_in       = mem_data(pend_a);
      raddr             = pend_a;
      from_pend         = 1'b1;
    end else begin
      cif.inst_ready_in = 1'b0;
      cif.inst_in       = 32'h0;
    end
    #1;
    exp_req = rdy && !pend && (exp_cnt < DEPTH) && !rob_clear && !redirect_in;
    chk("inst_req", cif.inst_req, exp_req);
    if (cif.inst_req && !pend) begin
      accepted        = 1'b1;
      cif.inst_handle = 1'b1;
      raddr           = cif.inst_addr;
      chk("req_addr", cif.inst_addr, exp_pc);
      if (lat == 0) begin
        cif.inst_ready_in = 1'b1;
        cif.inst_in       = mem_data(raddr);
      end
    end
    #1;
    resp_now = rdy && cif.inst_ready_in;
    pushed   = resp_now && !fl && !(from_pend && drop);
    if (pushed) sb.push_back({mem_data(raddr), raddr});
    exp_rdy = !fl && (exp_cnt > 0 || (BYP && pushed));
    chk("ready_out", inst_ready_out, exp_rdy);
    popped = rdy && deq && exp_rdy;
    if (popped && sb.size() > 0) begin
      ent = sb.pop_front();
      chk("head_inst", inst_out, ent[63:32]);
      chk("head_addr", inst_addr_out, ent[31:0]);
    end
    if (fl) begin
      sb.delete();
      exp_cnt = 0;
      exp_pc  = rob_clear ? rob_rst_addr : redirect_pc_in;
      if (pend && !from_pend) drop = 1'b1;
    end else begin
      exp_cnt = exp_cnt + int'(pushed) - int'(popped);
    end
    if (from_pend) drop = 1'b0;
    if (accepted) exp_pc = exp_pc + 32'h4;
    @(posedge clk);
    #1;
    if (rdy) begin
      if (from_pend) pend = 1'b0;
      else if (pend) wait_cnt--;
      if (accepted && lat > 0) begin
        pend     = 1'b1;
        pend_a   = raddr;
        wait_cnt = lat - 1;
      end
    end
    chk("count", count_out, exp_cnt);
    cif.inst_ready_in = 1'b0;
    cif.inst_handle   = 1'b0;
  endtask

  task automatic wait_no_pend();
    for (int i = 0; i < 12 && pend; i++) cyc();
    chk("idle_timeout", pend, 1'b0);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; deq = 1'b0;
    redirect_in = 1'b0; redirect_pc_in = 32'h0;
    rob_clear = 1'b0; rob_rst_addr = 32'h0;
    cif.inst_handle = 1'b0; cif.inst_ready_in = 1'b0; cif.inst_in = 32'h0;
    exp_cnt = 0; exp_pc = 32'h0; lat = 1; pend = 1'b0; drop = 1'b0;
    pend_a = 32'h0; wait_cnt = 0; junk_cnt = 32'h0;

    // reset values while reset is held
    @(posedge clk); #1;
    chk("rst_req", cif.inst_req, 1'b0);
    chk("rst_ready", inst_ready_out, 1'b0);
    chk("rst_count", count_out, 0);
    chk("rst_inst", inst_out, 32'h0);
    chk("rst_iaddr", inst_addr_out, 32'h0);
    chk("rst_pc", cif.inst_addr, 32'h0);
    rst = 1'b0;

    // fill: requests 0,4,8,C then stall
    repeat (8) cyc();
    chk("fill_count", count_out, 4);
    chk("full_noreq", cif.inst_req, 1'b0);

    // single dequeue from full
    deq = 1'b1;
    cyc();
    deq = 1'b0;
    chk("deq_count", count_out, 3);
    chk("next_req", cif.inst_addr, 32'h10);
    cyc();

    // streaming with simultaneous push and pop
    deq = 1'b1;
    repeat (12) cyc();

    // flush in WAIT, response 3 cycles later must be dropped
    deq = 1'b0;
    wait_no_pend();
    lat = 4;
    for (int i = 0; i < 12 && !pend; i++) cyc();
    chk("reach_wait", pend, 1'b1);
    rob_clear = 1'b1; rob_rst_addr = 32'h100;
    cyc();
    rob_clear = 1'b0;
    chk("clr_empty", count_out, 0);
    lat = 1;
    repeat (8) cyc();
    chk("first_addr", inst_addr_out, 32'h100);
    deq = 1'b1;
    repeat (4) cyc();

    // rob_clear wins over redirect
    rob_clear = 1'b1; rob_rst_addr = 32'h200;
    redirect_in = 1'b1; redirect_pc_in = 32'h300;
    cyc();
    rob_clear = 1'b0; redirect_in = 1'b0;
    chk("clr_prio", cif.inst_addr, 32'h200);
    repeat (4) cyc();

    // global stall with spurious responses
    deq = 1'b0;
    repeat (3) cyc();
    rdy = 1'b0; deq = 1'b1;
    saved_cnt = exp_cnt;
    repeat (5) cyc();
    chk("rdy_hold_cnt", count_out, saved_cnt);
    chk("rdy_hold_pc", cif.inst_addr, exp_pc);
    rdy = 1'b1; deq = 1'b0;

    // response into empty queue at 0x40
    wait_no_pend();
    redirect_in = 1'b1; redirect_pc_in = 32'h40;
    cyc();
    redirect_in = 1'b0;
    repeat (3) cyc();
    chk("beef_inst", inst_out, 32'hDEAD_BEEF);
    chk("beef_addr", inst_addr_out, 32'h40);

    // zero-latency cache then drain
    deq = 1'b1;
    lat = 0;
    repeat (10) cyc();
    lat = 1;
    repeat (10) cyc();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
